instr_fetch_ctrl: RTL and testbench

//  Sequences the instruction memory read port: owns the fetch PC, drives mem_addr/mem_re,
//  and captures each returned word with its PC into a small FIFO toward decode.

---
 rtl/instr_fetch_if.sv | 30 +++
 rtl/instr_fetch_ctrl.sv | 102 ++++++++++
 tb/tb_instr_fetch_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - memory-read, redirect/halt and decode-handshake bundle of the fetch controller
interface instr_fetch_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int DEPTH       = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_re;
  logic [INSTR_WIDTH-1:0] mem_instr;
  logic                   halt;
  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0]  out_pc;
  logic [CW-1:0]          fifo_count;

  modport slave (
    output mem_addr, mem_re, out_valid, out_instr, out_pc, fifo_count,
    input  mem_instr, halt, redirect_valid, redirect_pc, out_ready
  );

  modport master (
    input  mem_addr, mem_re, out_valid, out_instr, out_pc, fifo_count,
    output mem_instr, halt, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - fetch PC sequencer feeding a small {instr, pc} FIFO toward decode
module instr_fetch_ctrl #(
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    ADDR_WIDTH  = 10,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    DEPTH       = 2
) (
  input  logic        clk,
  input  logic        rst,
  instr_fetch_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = INSTR_WIDTH + ADDR_WIDTH;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [EW-1:0]         r_fifo [DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  logic                  w_out_valid;
  logic                  w_pop;
  logic                  w_has_room;
  logic                  w_issue;
  logic [ADDR_WIDTH-1:0] w_redir_pc;
  logic [EW-1:0]         w_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Leaving HALT is registered, so issue restarts one cycle after halt drops.
  always_comb begin
    w_state_nxt = r_state;
    w_out_valid = 1'b0;
    w_pop       = 1'b0;
    w_has_room  = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_RUN:   if (bus.halt)  w_state_nxt = S_HALT;
      S_HALT:  if (!bus.halt) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
    w_out_valid = (r_count != '0) && !bus.redirect_valid;
    w_pop       = w_out_valid && bus.out_ready;
    w_has_room  = (r_count < CW'(DEPTH)) || w_pop;
    w_issue     = (r_state == S_RUN) && !bus.halt && !bus.redirect_valid && w_has_room && !rst;
  end

  assign w_redir_pc = bus.redirect_pc & ~ADDR_WIDTH'(3);
  assign w_head     = r_fifo[r_rptr];

  assign bus.mem_addr   = r_pc;
  assign bus.mem_re     = w_issue;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_instr  = w_head[EW-1:ADDR_WIDTH];
  assign bus.out_pc     = w_head[ADDR_WIDTH-1:0];
  assign bus.fifo_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      r_pc    <= w_redir_pc;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_issue) begin
        r_fifo[r_wptr] <= {bus.mem_instr, r_pc};
        r_wptr         <= r_wptr + PW'(1);
        r_pc           <= r_pc + ADDR_WIDTH'(4);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_issue && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_issue && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - scoreboard bench for instr_fetch_ctrl against a queue-based fetch model
module tb_instr_fetch_ctrl;
  localparam int             IW       = 32;
  localparam int             AW       = 10;
  localparam int             DEPTH    = 2;
  localparam logic [AW-1:0]  RESET_PC = 10'h000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

  instr_fetch_ctrl #(
    .INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .RESET_PC(RESET_PC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  function automatic logic [IW-1:0] word_of(input logic [AW-1:0] a);
    return {a, 12'hABC, a};
  endfunction

  assign bus.mem_instr = word_of(bus.mem_addr);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: expected FIFO contents as a queue of fetch PCs.
  logic [AW-1:0] m_pc;
  int            m_cnt;
  bit            m_run;
  logic [AW-1:0] sb_q[$];
  logic          e_valid, e_pop, e_issue;

  // Monitor: on every DUT handshake, the head must be the oldest expected fetch.
  always begin
    @(negedge clk);
    #1;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check("pop_with_empty_model", 32'(bus.out_pc), 32'hFFFF_FFFF);
      end else begin
        logic [AW-1:0] e;
        e = sb_q.pop_front();
        check("out_pc", 32'(bus.out_pc), 32'(e));
        check("out_instr", bus.out_instr, word_of(e));
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      check("rst_mem_re", 32'(bus.mem_re), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'(RESET_PC));
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
      check("rst_out_instr", bus.out_instr, 32'd0);
      check("rst_out_pc", 32'(bus.out_pc), 32'd0);
      m_pc  = RESET_PC;
      m_cnt = 0;
      m_run = 1'b1;
      sb_q.delete();
    end else begin
      e_valid = (m_cnt > 0) && !bus.redirect_valid;
      e_pop   = e_valid && bus.out_ready;
      e_issue = m_run && !bus.halt && !bus.redirect_valid && ((m_cnt < DEPTH) || e_pop);
      check("mem_re", 32'(bus.mem_re), 32'(e_issue));
      check("mem_addr", 32'(bus.mem_addr), 32'(m_pc));
      check("out_valid", 32'(bus.out_valid), 32'(e_valid));
      check("fifo_count", 32'(bus.fifo_count), 32'(m_cnt));
      if (bus.redirect_valid) begin
        sb_q.delete();
        m_cnt = 0;
        m_pc  = {bus.redirect_pc[AW-1:2], 2'b00};
      end else begin
        if (e_issue) begin
          sb_q.push_back(m_pc);
          m_pc = m_pc + 10'd4;
        end
        m_cnt = m_cnt + int'(e_issue) - int'(e_pop);
      end
      m_run = !bus.halt;
    end
  end

  task automatic step(input logic r, input logic h, input logic rv, input logic [AW-1:0] rp, input logic rdy);
    @(negedge clk);
    rst                = r;
    bus.halt           = h;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    bus.out_ready      = rdy;
  endtask

  initial begin
    rst                = 1'b1;
    bus.halt           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    repeat (2) step(1, 0, 0, '0, 1);
    repeat (6) step(0, 0, 0, '0, 1);
    // Back-pressure from a fresh reset: FIFO fills, fetch stalls at 0x8, then drains gap-free.
    step(1, 0, 0, '0, 0);
    repeat (5) step(0, 0, 0, '0, 0);
    repeat (4) step(0, 0, 0, '0, 1);
    // Redirect with two entries queued; low address bits must be dropped.
    repeat (3) step(0, 0, 0, '0, 0);
    step(0, 0, 1, 10'h013, 1);
    repeat (4) step(0, 0, 0, '0, 1);
    // Halt with an entry in flight, then resume at the frozen pc.
    step(0, 0, 0, '0, 0);
    repeat (4) step(0, 1, 0, '0, 1);
    repeat (4) step(0, 0, 0, '0, 1);
    // Redirect during halt only moves the pc.
    step(0, 1, 0, '0, 1);
    step(0, 1, 1, 10'h1A6, 1);
    step(0, 1, 0, '0, 1);
    repeat (3) step(0, 0, 0, '0, 1);
    // PC wrap at the top of the address space.
    step(0, 0, 1, 10'h3F8, 1);
    repeat (5) step(0, 0, 0, '0, 1);
    // Reset mid-stream with a full FIFO.
    repeat (3) step(0, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    repeat (4) step(0, 0, 0, '0, 1);
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) < 1),
           ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 6),
           AW'($urandom_range(0, 1023)),
           ($urandom_range(0, 99) < 70));
    end
    repeat (3) step(0, 0, 0, '0, 1);
    @(negedge clk);
    #5;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
